// File: rtl/icbr_pkg.sv
// Shared definitions for the instruction-cache to AXI3 read bridge.
// Holds the bridge FSM state encoding and the AXI burst/response constants.
// Imported by icache_axi_rd_bridge.
package icbr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Purpose: converts sramlike instruction-cache read requests into single-beat AXI3 reads.
// Latency: addr_ok in T, arvalid in T+1, data_ok combinationally with the rlast beat (>= T+2).
// Backpressure: one outstanding read; addr_ok held low until data_ok, arvalid/araddr stable until arready.
//
// Ports:
//   clk, resetn                       - clock, asynchronous active-low reset
//   cache_inst_*                      - sramlike request/response from the instruction cache
//                                       (wr and wdata are ignored: every request is a read)
//   arid..arvalid, arready            - AXI3 read-address channel
//   rid..rvalid, rready               - AXI3 read-data channel (rid not checked)
//   err_valid, err_addr               - only with ICBR_ERR_EN defined: sticky first-error flag and
//                                       the address of the first read that returned a non-OKAY rresp
module icache_axi_rd_bridge
    import icbr_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        cache_inst_req,
    input  logic        cache_inst_wr,
    input  logic [1:0]  cache_inst_size,
    input  logic [31:0] cache_inst_addr,
    input  logic [31:0] cache_inst_wdata,
    output logic [31:0] cache_inst_rdata,
    output logic        cache_inst_addr_ok,
    output logic        cache_inst_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
`ifdef ICBR_ERR_EN
    ,
    output logic        err_valid,
    output logic [31:0] err_addr
`endif
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        last_beat;

`ifdef ICBR_ERR_EN
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        unused_in;
    assign unused_in = ^{cache_inst_wr, cache_inst_wdata, rid};
`else
    logic        unused_in;
    assign unused_in = ^{cache_inst_wr, cache_inst_wdata, rid, rresp};
`endif

    // Only the final beat completes the read; earlier beats are drained and dropped.
    assign last_beat = (state_q == ST_R) && rvalid && rlast;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        case (state_q)
            ST_IDLE: begin
                if (cache_inst_req) begin
                    addr_d  = cache_inst_addr;
                    size_d  = cache_inst_size;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (rvalid && rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ICBR_ERR_EN
    // Only the first failing read is recorded; later errors leave the capture untouched.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (last_beat && (rresp != AXI_RESP_OKAY) && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
`ifdef ICBR_ERR_EN
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
`ifdef ICBR_ERR_EN
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
`endif
        end
    end

    // Handshake outputs decode straight from the state flop, so the async reset
    // drops arvalid/rready/data_ok in the same cycle it is asserted.
    assign cache_inst_addr_ok = (state_q == ST_IDLE) && cache_inst_req && resetn;
    assign cache_inst_data_ok = last_beat;
    assign cache_inst_rdata   = last_beat ? rdata : 32'd0;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;
    assign arvalid = (state_q == ST_AR);
    assign rready  = (state_q == ST_R);

`ifdef ICBR_ERR_EN
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Purpose: self-checking bench for icache_axi_rd_bridge (directed vectors, scoreboard monitors).
// Latency: expects addr_ok at T, arvalid at T+1, data_ok at T+2 with an immediately-ready slave.
// Backpressure: exercises arready stalls, back-to-back requests and mid-transaction reset.
module tb_icache_axi_rd_bridge;

    logic        clk;
    logic        resetn;
    logic        cache_inst_req;
    logic        cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr;
    logic [31:0] cache_inst_wdata;
    logic [31:0] cache_inst_rdata;
    logic        cache_inst_addr_ok;
    logic        cache_inst_data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
`ifdef ICBR_ERR_EN
    logic        err_valid;
    logic [31:0] err_addr;
`endif

    icache_axi_rd_bridge #(.AXI_ID(4'd0)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .cache_inst_req     (cache_inst_req),
        .cache_inst_wr      (cache_inst_wr),
        .cache_inst_size    (cache_inst_size),
        .cache_inst_addr    (cache_inst_addr),
        .cache_inst_wdata   (cache_inst_wdata),
        .cache_inst_rdata   (cache_inst_rdata),
        .cache_inst_addr_ok (cache_inst_addr_ok),
        .cache_inst_data_ok (cache_inst_data_ok),
        .arid               (arid),
        .araddr             (araddr),
        .arlen              (arlen),
        .arsize             (arsize),
        .arburst            (arburst),
        .arvalid            (arvalid),
        .arready            (arready),
        .rid                (rid),
        .rdata              (rdata),
        .rresp              (rresp),
        .rlast              (rlast),
        .rvalid             (rvalid),
        .rready             (rready)
`ifdef ICBR_ERR_EN
        ,
        .err_valid          (err_valid),
        .err_addr           (err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_exp_t;

    ar_exp_t     exp_ar[$];
    logic [31:0] exp_r[$];
    int          tests_run;
    int          tests_failed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Read-address channel monitor: every accepted AR must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", 32'd1, 32'd0);
                end else begin
                    ar_exp_t e;
                    e = exp_ar.pop_front();
                    chk("ar_addr",  araddr, e.addr);
                    chk("ar_size",  {29'd0, arsize}, {29'd0, e.size});
                    chk("ar_len",   {28'd0, arlen}, 32'd0);
                    chk("ar_burst", {30'd0, arburst}, 32'd1);
                    chk("ar_id",    {28'd0, arid}, 32'd0);
                end
            end
        end
    end

    // Response monitor: data_ok pops the expected word; otherwise rdata must read zero.
    initial begin
        forever begin
            @(negedge clk);
            if (cache_inst_data_ok) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("r_rdata", cache_inst_rdata, exp_r.pop_front());
                end
            end else begin
                chk("rdata_idle_zero", cache_inst_rdata, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single read against a slave that accepts AR at once and returns rlast the next cycle.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        ar_exp_t e;
        tick();
        cache_inst_req  = 1'b1;
        cache_inst_addr = a;
        cache_inst_size = 2'd2;
        e.addr = a;
        e.size = 3'b010;
        exp_ar.push_back(e);
        @(negedge clk);
        chk("txn_addr_ok_T", {31'd0, cache_inst_addr_ok}, 32'd1);
        tick();
        cache_inst_req = 1'b0;
        @(negedge clk);
        chk("txn_arvalid_T1", {31'd0, arvalid}, 32'd1);
        chk("txn_no_data_T1", {31'd0, cache_inst_data_ok}, 32'd0);
        tick();
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = d;
        rresp  = resp;
        exp_r.push_back(d);
        @(negedge clk);
        chk("txn_data_ok_T2", {31'd0, cache_inst_data_ok}, 32'd1);
        chk("txn_rready_T2",  {31'd0, rready}, 32'd1);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        @(negedge clk);
        chk("txn_idle_after", {31'd0, cache_inst_data_ok | arvalid | rready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ar_exp_t e;
        tests_run        = 0;
        tests_failed     = 0;
        resetn           = 1'b0;
        cache_inst_req   = 1'b0;
        cache_inst_wr    = 1'b0;
        cache_inst_size  = 2'd0;
        cache_inst_addr  = 32'd0;
        cache_inst_wdata = 32'hA5A5A5A5;
        arready          = 1'b1;
        rid              = 4'd3;
        rdata            = 32'd0;
        rresp            = 2'b00;
        rlast            = 1'b0;
        rvalid           = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready",  {31'd0, rready}, 32'd0);
        chk("rst_data_ok", {31'd0, cache_inst_data_ok}, 32'd0);
        chk("rst_araddr",  araddr, 32'd0);
        chk("rst_arsize",  {29'd0, arsize}, 32'd0);
        #2;
        resetn = 1'b1;

        // Minimum-latency read
        do_txn(32'hBFC00000, 32'h3C08BFC0, 2'b00);

        // arready held low for 5 cycles while the cache keeps req high
        arready = 1'b0;
        tick();
        cache_inst_req  = 1'b1;
        cache_inst_addr = 32'h00001000;
        cache_inst_size = 2'd2;
        e.addr = 32'h00001000;
        e.size = 3'b010;
        exp_ar.push_back(e);
        @(negedge clk);
        chk("stall_addr_ok_T", {31'd0, cache_inst_addr_ok}, 32'd1);
        tick();
        cache_inst_addr = 32'h00002000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
            chk("stall_araddr",  araddr, 32'h00001000);
            chk("stall_no_addr_ok", {31'd0, cache_inst_addr_ok}, 32'd0);
            tick();
        end
        arready        = 1'b1;
        cache_inst_req = 1'b0;
        @(negedge clk);
        chk("stall_arvalid_release", {31'd0, arvalid}, 32'd1);
        tick();
        rvalid = 1'b1;
        rlast  = 1'b0;
        rdata  = 32'hDEAD0000;
        @(negedge clk);
        chk("nonlast_no_data_ok", {31'd0, cache_inst_data_ok}, 32'd0);
        chk("nonlast_rready",     {31'd0, rready}, 32'd1);
        tick();
        rlast = 1'b1;
        rdata = 32'h11112222;
        exp_r.push_back(32'h11112222);
        @(negedge clk);
        chk("stall_data_ok", {31'd0, cache_inst_data_ok}, 32'd1);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;

        // Back-to-back requests with req held high
        cache_inst_req  = 1'b1;
        cache_inst_addr = 32'h00000100;
        cache_inst_size = 2'd2;
        e.addr = 32'h00000100;
        e.size = 3'b010;
        exp_ar.push_back(e);
        @(negedge clk);
        chk("b2b_first_addr_ok", {31'd0, cache_inst_addr_ok}, 32'd1);
        tick();
        cache_inst_addr = 32'h00000104;
        e.addr = 32'h00000104;
        exp_ar.push_back(e);
        @(negedge clk);
        chk("b2b_hold_ar", {31'd0, cache_inst_addr_ok}, 32'd0);
        tick();
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'hAAAA0100;
        exp_r.push_back(32'hAAAA0100);
        @(negedge clk);
        chk("b2b_hold_r", {31'd0, cache_inst_addr_ok}, 32'd0);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        @(negedge clk);
        chk("b2b_second_addr_ok", {31'd0, cache_inst_addr_ok}, 32'd1);
        tick();
        cache_inst_req = 1'b0;
        @(negedge clk);
        chk("b2b_second_arvalid", {31'd0, arvalid}, 32'd1);
        tick();
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'hBBBB0104;
        exp_r.push_back(32'hBBBB0104);
        @(negedge clk);
        chk("b2b_second_data_ok", {31'd0, cache_inst_data_ok}, 32'd1);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;

        // Error response still completes; then OKAY on the next word
        do_txn(32'h1FAF0000, 32'hE0E0E0E0, 2'b10);
`ifdef ICBR_ERR_EN
        chk("err_valid_set", {31'd0, err_valid}, 32'd1);
        chk("err_addr_set",  err_addr, 32'h1FAF0000);
`endif
        do_txn(32'h1FAF0004, 32'h12345678, 2'b00);
`ifdef ICBR_ERR_EN
        chk("err_valid_kept", {31'd0, err_valid}, 32'd1);
        chk("err_addr_kept",  err_addr, 32'h1FAF0000);
`endif

        // Reset while in R with the last beat on the bus
        tick();
        cache_inst_req  = 1'b1;
        cache_inst_addr = 32'h00000300;
        e.addr = 32'h00000300;
        e.size = 3'b010;
        exp_ar.push_back(e);
        tick();
        cache_inst_req = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_r_rready", {31'd0, rready}, 32'd1);
        #1;
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'hCAFECAFE;
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_mid_rready",  {31'd0, rready}, 32'd0);
        chk("rst_mid_data_ok", {31'd0, cache_inst_data_ok}, 32'd0);
        chk("rst_mid_araddr",  araddr, 32'd0);
`ifdef ICBR_ERR_EN
        chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
`endif
        rvalid = 1'b0;
        rlast  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        do_txn(32'h00000200, 32'h0BADF00D, 2'b00);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ar_queue_drained", exp_ar.size(), 32'd0);
        chk("r_queue_drained",  exp_r.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
